// File: rtl/seq_buffer_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : seq_buffer_streamer
//  Purpose  : Read-side master for the DNA sequence buffer. On an accepted
//             start it walks a window [base_addr, base_addr+length) of the
//             buffer (wrapping modulo DEPTH) through a combinational read
//             port and emits one base per beat on a valid/ready stream.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             start             - command strobe, sampled only in IDLE
//             base_addr, length - window to stream (length legal 1..DEPTH)
//             busy, done, err   - command status (done/err are 1-cycle pulses)
//             mem_r_addr/data   - buffer read port (data combinational)
//             m_valid, m_ready, m_data, m_last - output stream
//  Revision : 1.0 - initial release
// ============================================================================
module seq_buffer_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 128,
  parameter int PTR_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           base_addr,
  input  logic [7:0]            length,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           mem_r_addr,
  input  logic [31:0]           mem_r_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [8:0] LEN_MAX = 9'(DEPTH);

  state_t               state;
  state_t               state_nxt;
  logic [PTR_WIDTH-1:0] ptr;
  logic [7:0]           len_q;
  logic [7:0]           cnt;
  logic                 len_ok;
  logic                 accept;

  // Upper address/data bits are intentionally ignored.
  logic unused_bits;
  assign unused_bits = &{1'b0, base_addr[31:PTR_WIDTH], mem_r_data[31:DATA_WIDTH]};

  assign len_ok     = (length != 8'd0) && ({1'b0, length} <= LEN_MAX);
  assign accept     = m_valid && m_ready;
  assign mem_r_addr = {{(32-PTR_WIDTH){1'b0}}, ptr};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && len_ok) state_nxt = LOAD;
      LOAD:    state_nxt = STREAM;
      STREAM:  if (accept && m_last) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
      ptr     <= '0;
      len_q   <= 8'd0;
      cnt     <= 8'd0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              len_q <= length;
              ptr   <= base_addr[PTR_WIDTH-1:0];
              cnt   <= 8'd0;
              busy  <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          // First base: the read port already shows buffer[ptr].
          m_data  <= mem_r_data[DATA_WIDTH-1:0];
          m_valid <= 1'b1;
          m_last  <= (len_q == 8'd1);
          ptr     <= ptr + PTR_WIDTH'(1);
          cnt     <= 8'd1;
        end
        STREAM: begin
          if (accept) begin
            if (m_last) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              // Registered so it is high exactly during the FINISH cycle.
              done    <= 1'b1;
            end else begin
              // Reload on the accepting edge for back-to-back beats.
              // cnt counts bases already loaded, so the next one is last
              // when cnt reaches len_q-1.
              m_data <= mem_r_data[DATA_WIDTH-1:0];
              m_last <= (cnt == (len_q - 8'd1));
              ptr    <= ptr + PTR_WIDTH'(1);
              cnt    <= cnt + 8'd1;
            end
          end
        end
        FINISH: begin
          busy <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_buffer_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_buffer_streamer
//  Purpose  : Directed self-checking bench for seq_buffer_streamer with a
//             behavioural 128-entry buffer on the combinational read port.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_buffer_streamer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [7:0]  length;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] mem_r_addr;
  logic [31:0] mem_r_data;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;

  logic [31:0] mem [0:127];
  logic [7:0]  exp_q [$];

  int vectors;
  int miscompares;

  seq_buffer_streamer #(
    .DATA_WIDTH(8),
    .DEPTH(128),
    .PTR_WIDTH(7)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .length(length),
    .busy(busy),
    .done(done),
    .err(err),
    .mem_r_addr(mem_r_addr),
    .mem_r_data(mem_r_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_last(m_last)
  );

  assign mem_r_data = mem[mem_r_addr[6:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and follow it to completion. rpat[i % rlen] is m_ready
  // in the i-th cycle after the LOAD cycle. exp_q, when filled, overrides the
  // buffer-derived expectation for the leading beats.
  task automatic run_cmd(input int base, input int len, input logic [15:0] rpat,
                         input int rlen, input bit start_in_finish);
    int beats;
    int cyc;
    logic [7:0] exp_d;
    base_addr = 32'(base);
    length    = 8'(len);
    start     = 1'b1;
    m_ready   = 1'b0;
    step();
    start = 1'b0;
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_valid", 32'(m_valid), 32'd0);
    step();
    beats = 0;
    cyc   = 0;
    while (beats < len && cyc < 400) begin
      m_ready = rpat[cyc % rlen];
      chk("valid", 32'(m_valid), 32'd1);
      if (!m_valid) break;
      exp_d = (beats < exp_q.size()) ? exp_q[beats] : mem[(base + beats) % 128][7:0];
      chk("data", 32'(m_data), 32'(exp_d));
      chk("last", 32'(m_last), 32'(beats == len - 1));
      chk("addr", mem_r_addr, 32'((base + beats + 1) % 128));
      if (m_ready) beats++;
      step();
      cyc++;
    end
    m_ready = 1'b0;
    chk("beats", 32'(beats), 32'(len));
    chk("done", 32'(done), 32'd1);
    chk("fin_valid", 32'(m_valid), 32'd0);
    chk("fin_busy", 32'(busy), 32'd1);
    if (start_in_finish) begin
      base_addr = 32'd0;
      length    = 8'd4;
      start     = 1'b1;
    end
    step();
    start = 1'b0;
    chk("done_clr", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_err", 32'(err), 32'd0);
    step();
    chk("idle_valid", 32'(m_valid), 32'd0);
    chk("idle_busy2", 32'(busy), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    start       = 1'b0;
    base_addr   = 32'd0;
    length      = 8'd0;
    m_ready     = 1'b0;
    // Junk in the upper bytes must never reach m_data.
    for (int i = 0; i < 128; i++) begin
      mem[i] = {8'hC0, 8'(i), 8'h5A, 8'(i * 7 + 3)};
    end

    // Reset state
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_addr", mem_r_addr, 32'd0);
    rst = 1'b0;
    step();

    // A, C, G, T from base 0
    mem[0] = 32'h1234_5641;
    mem[1] = 32'hFFFF_FF43;
    mem[2] = 32'h0000_0147;
    mem[3] = 32'h8000_0054;
    exp_q = '{8'h41, 8'h43, 8'h47, 8'h54};
    run_cmd(0, 4, 16'h0001, 1, 1'b0);

    // Wrap 126 -> 127 -> 0, with a start presented during FINISH
    mem[126] = 32'hAAAA_AA11;
    mem[127] = 32'h5555_5522;
    mem[0]   = 32'h0F0F_0F33;
    exp_q = '{8'h11, 8'h22, 8'h33};
    run_cmd(126, 3, 16'h0001, 1, 1'b1);

    // Backpressure: ready 1,0,0,1,0,1,1
    run_cmd(10, 4, 16'h0069, 7, 1'b0);

    // Illegal lengths
    base_addr = 32'd3;
    length    = 8'd0;
    start     = 1'b1;
    step();
    start = 1'b0;
    chk("err_len0", 32'(err), 32'd1);
    chk("err_len0_busy", 32'(busy), 32'd0);
    step();
    chk("err_len0_clr", 32'(err), 32'd0);
    chk("err_len0_valid", 32'(m_valid), 32'd0);
    length = 8'd200;
    start  = 1'b1;
    step();
    start = 1'b0;
    chk("err_len200", 32'(err), 32'd1);
    chk("err_len200_busy", 32'(busy), 32'd0);
    step();
    chk("err_len200_clr", 32'(err), 32'd0);
    chk("err_len200_valid", 32'(m_valid), 32'd0);
    chk("err_len200_busy2", 32'(busy), 32'd0);

    // Edge lengths
    run_cmd(50, 1, 16'h0001, 1, 1'b0);
    run_cmd(5, 128, 16'h0001, 1, 1'b0);

    // Reset mid-stream after two beats of a len=10 command
    base_addr = 32'd20;
    length    = 8'd10;
    start     = 1'b1;
    step();
    start   = 1'b0;
    m_ready = 1'b1;
    step();
    step();
    step();
    chk("mid_data", 32'(m_data), 32'(mem[22][7:0]));
    rst = 1'b1;
    step();
    rst     = 1'b0;
    m_ready = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(m_valid), 32'd0);
    chk("abort_last", 32'(m_last), 32'd0);
    chk("abort_data", 32'(m_data), 32'd0);
    chk("abort_addr", mem_r_addr, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_no_done", 32'(done), 32'd0);
    end
    run_cmd(60, 3, 16'h0001, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
